inst_fetch: RTL and testbench



---
 rtl/inst_fetch.sv | 213 +++++++++++++++++++++
 tb/tb_inst_fetch.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//
// Instruction fetch stage of the pipelined RV32 core. Owns the program counter,
// runs the single-outstanding instruction-memory request/acknowledge handshake,
// and buffers up to two fetched {instruction, PC} pairs in a small FIFO whose
// head feeds the IF/ID instruction register.
//
// Ports
//   clk             clock
//   rst             synchronous, active-high reset
//   stall           IF/ID not accepting this cycle (hazard unit)
//   redirect_valid  one-cycle pulse: control-flow change from execute
//   redirect_pc     redirect target; bits [1:0] are ignored
//   imem_req        request outstanding (registered)
//   imem_addr       word-aligned request address, stable until ack
//   imem_ack        response valid this cycle
//   imem_rdata      instruction data, valid with imem_ack
//   inst_out        FIFO head instruction (0 when empty)
//   pc_out          PC of inst_out (0 when empty)
//   inst_valid      FIFO non-empty
//   bubble          ~inst_valid, drives IF/ID rst_ir
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter int                   BUS_WIDTH = 32,
    parameter logic [BUS_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [BUS_WIDTH-1:0] redirect_pc,
    output logic                 imem_req,
    output logic [BUS_WIDTH-1:0] imem_addr,
    input  logic                 imem_ack,
    input  logic [BUS_WIDTH-1:0] imem_rdata,
    output logic [BUS_WIDTH-1:0] inst_out,
    output logic [BUS_WIDTH-1:0] pc_out,
    output logic                 inst_valid,
    output logic                 bubble
);

    localparam int                   DEPTH   = 2;
    localparam logic [BUS_WIDTH-1:0] PC_STEP = BUS_WIDTH'(4);

    // IDLE: nothing outstanding.
    // BUSY: request at fetch_pc outstanding, its data will be kept.
    // DROP: request outstanding whose data must be thrown away because a
    //       redirect arrived while it was in flight; pending_pc holds where
    //       fetching continues once the stale response has been absorbed.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic                 req_reg;
    logic [BUS_WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
    logic [BUS_WIDTH-1:0] pending_pc_reg, pending_pc_next;

    // Two-entry FIFO of {inst, pc}; tiny, so it lives in flops.
    logic [BUS_WIDTH-1:0] fifo_inst_reg [DEPTH];
    logic [BUS_WIDTH-1:0] fifo_pc_reg   [DEPTH];
    logic                 rd_ptr_reg, rd_ptr_next;
    logic                 wr_ptr_reg, wr_ptr_next;
    logic [1:0]           count_reg, count_next;

    logic                 pop;
    logic                 push;
    logic                 flush;
    logic [1:0]           count_after_pop;
    logic [BUS_WIDTH-1:0] redirect_target;

    // The low two target bits are forced to zero; keep lint quiet about them.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign redirect_target      = {redirect_pc[BUS_WIDTH-1:2], 2'b00};

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            req_reg        <= 1'b0;
            fetch_pc_reg   <= RESET_PC;
            pending_pc_reg <= RESET_PC;
            count_reg      <= 2'd0;
            rd_ptr_reg     <= 1'b0;
            wr_ptr_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            // imem_req is a flop of its own so the bus sees a clean signal.
            req_reg        <= (state_next != ST_IDLE);
            fetch_pc_reg   <= fetch_pc_next;
            pending_pc_reg <= pending_pc_next;
            count_reg      <= count_next;
            rd_ptr_reg     <= rd_ptr_next;
            wr_ptr_reg     <= wr_ptr_next;
        end
    end

    // FIFO storage. Contents need no reset: the outputs are gated by count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_reg == 1'(gi))) begin
                fifo_inst_reg[gi] <= imem_rdata;
                fifo_pc_reg[gi]   <= fetch_pc_reg;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        fetch_pc_next   = fetch_pc_reg;
        pending_pc_next = pending_pc_reg;
        push            = 1'b0;
        flush           = 1'b0;
        count_next      = count_reg;
        rd_ptr_next     = rd_ptr_reg;
        wr_ptr_next     = wr_ptr_reg;

        // A redirect flushes, so it never counts as a consume.
        pop             = (count_reg != 2'd0) && !stall && !redirect_valid;
        count_after_pop = count_reg - {1'b0, pop};

        if (redirect_valid) begin
            flush = 1'b1;
            unique case (state_reg)
                ST_IDLE: begin
                    fetch_pc_next = redirect_target;
                    state_next    = ST_BUSY;
                end
                ST_BUSY: begin
                    if (imem_ack) begin
                        // The returning word is stale; restart at the target.
                        fetch_pc_next = redirect_target;
                        state_next    = ST_BUSY;
                    end else begin
                        // Address must stay put until the ack, so park the
                        // target and swallow the in-flight response.
                        pending_pc_next = redirect_target;
                        state_next      = ST_DROP;
                    end
                end
                ST_DROP: begin
                    pending_pc_next = redirect_target;
                    if (imem_ack) begin
                        fetch_pc_next = redirect_target;
                        state_next    = ST_BUSY;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    // Only issue when the response is guaranteed a slot.
                    if (count_after_pop < 2'd2) begin
                        state_next = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (imem_ack) begin
                        push          = 1'b1;
                        fetch_pc_next = fetch_pc_reg + PC_STEP;
                        // After the push the FIFO holds count_after_pop + 1;
                        // keep requesting only while that leaves a free slot.
                        state_next    = (count_after_pop == 2'd0) ? ST_BUSY : ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (imem_ack) begin
                        fetch_pc_next = pending_pc_reg;
                        state_next    = ST_BUSY;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end

        if (flush) begin
            count_next  = 2'd0;
            rd_ptr_next = 1'b0;
            wr_ptr_next = 1'b0;
        end else begin
            count_next  = count_after_pop + {1'b0, push};
            rd_ptr_next = rd_ptr_reg ^ pop;
            wr_ptr_next = wr_ptr_reg ^ push;
        end
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        imem_req   = req_reg;
        imem_addr  = fetch_pc_reg;
        inst_valid = (count_reg != 2'd0);
        bubble     = (count_reg == 2'd0);
        inst_out   = '0;
        pc_out     = '0;
        if (count_reg != 2'd0) begin
            inst_out = fifo_inst_reg[rd_ptr_reg];
            pc_out   = fifo_pc_reg[rd_ptr_reg];
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//
// Self-checking bench for inst_fetch. A memory model answers the handshake
// (fixed wait states or random ack). A queue-based reference model predicts
// every output each cycle; a table of hand-computed vectors and a few directed
// sequences cover startup, stall, redirect, reset and PC wrap corner cases.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] XORPAT   = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        inst_valid;
    logic        bubble;

    inst_fetch #(
        .BUS_WIDTH(32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .inst_out      (inst_out),
        .pc_out        (pc_out),
        .inst_valid    (inst_valid),
        .bubble        (bubble)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- memory model ----------------
    int ws        = 0;   // wait states per request
    int waited    = 0;
    bit rand_mode = 0;   // random ack instead of fixed wait states
    bit rand_data = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc   = RESET_PC;
    logic [31:0] m_pend = RESET_PC;
    bit          m_out  = 0;   // request outstanding
    bit          m_disc = 0;   // outstanding response is to be discarded

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Decide this cycle's memory response from what the DUT is presenting.
    task automatic mem_drive();
        if (rst || imem_req !== 1'b1) begin
            imem_ack = 1'b0;
            waited   = 0;
        end else if (rand_mode) begin
            imem_ack = ($urandom_range(0, 2) == 0);
        end else if (waited >= ws) begin
            imem_ack = 1'b1;
            waited   = 0;
        end else begin
            imem_ack = 1'b0;
            waited++;
        end
        if (imem_ack)
            imem_rdata = rand_data ? $urandom : (imem_addr ^ XORPAT);
        else
            imem_rdata = 32'hDEAD_BEEF;
    endtask

    // Reference behaviour at a clock edge, from the fetch rules directly.
    task automatic model_update();
        logic [31:0] tgt;
        ent_t        e;
        tgt = {redirect_pc[31:2], 2'b00};
        if (rst) begin
            mq.delete();
            m_pc   = RESET_PC;
            m_pend = RESET_PC;
            m_out  = 0;
            m_disc = 0;
        end else if (redirect_valid) begin
            mq.delete();
            if (!m_out || imem_ack) begin
                m_pc   = tgt;
                m_out  = 1;
                m_disc = 0;
            end else begin
                m_disc = 1;
                m_pend = tgt;
            end
        end else begin
            if (mq.size() > 0 && !stall) void'(mq.pop_front());
            if (m_out && imem_ack) begin
                if (m_disc) begin
                    m_pc   = m_pend;
                    m_disc = 0;
                end else begin
                    e.inst = imem_rdata;
                    e.pc   = m_pc;
                    mq.push_back(e);
                    m_pc  = m_pc + 32'd4;
                    m_out = (mq.size() < 2);
                end
            end else if (!m_out) begin
                m_out = (mq.size() < 2);
            end
        end
    endtask

    task automatic model_compare();
        logic        ev;
        logic [31:0] ei, ep;
        ev = (mq.size() > 0);
        ei = ev ? mq[0].inst : 32'h0;
        ep = ev ? mq[0].pc   : 32'h0;
        chk("model_imem_req",   32'(imem_req),   32'(m_out));
        chk("model_imem_addr",  imem_addr,       m_pc);
        chk("model_inst_valid", 32'(inst_valid), 32'(ev));
        chk("model_bubble",     32'(bubble),     32'(!ev));
        chk("model_inst_out",   inst_out,        ei);
        chk("model_pc_out",     pc_out,          ep);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        model_compare();
    endtask

    task automatic cyc(input logic s, input logic r, input logic [31:0] p);
        mem_drive();
        stall          = s;
        redirect_valid = r;
        redirect_pc    = p;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) begin
            mem_drive();
            tick();
        end
        rst = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        stall;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[15];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          found;
        bit          got_addr;
        bit          saw400;
        int          nv, nc;
        logic [31:0] prev, old_addr, new_addr;

        // Zero-wait stream from reset, then 6 cycles of stall with head at 0x10.
        tbl[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[1]  = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h00};
        tbl[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h04};
        tbl[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h08};
        tbl[4]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h0C};
        tbl[5]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h10};
        tbl[6]  = '{1'b1, 1'b0, 32'h18, 1'b1, 32'h10};
        tbl[7]  = '{1'b1, 1'b0, 32'h18, 1'b1, 32'h10};
        tbl[8]  = '{1'b1, 1'b0, 32'h18, 1'b1, 32'h10};
        tbl[9]  = '{1'b1, 1'b0, 32'h18, 1'b1, 32'h10};
        tbl[10] = '{1'b1, 1'b0, 32'h18, 1'b1, 32'h10};
        tbl[11] = '{1'b1, 1'b0, 32'h18, 1'b1, 32'h10};
        tbl[12] = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h14};
        tbl[13] = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h18};
        tbl[14] = '{1'b0, 1'b1, 32'h20, 1'b1, 32'h1C};

        // ---- reset state ----
        ws = 0; rand_mode = 0; rand_data = 0;
        do_reset();
        chk("rst_imem_req",   32'(imem_req),   32'h0);
        chk("rst_imem_addr",  imem_addr,       RESET_PC);
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("rst_inst_out",   inst_out,        32'h0);
        chk("rst_pc_out",     pc_out,          32'h0);
        chk("rst_bubble",     32'(bubble),     32'h1);
        $display("reset: req=%0b addr=%h valid=%0b bubble=%0b", imem_req, imem_addr, inst_valid, bubble);

        // ---- table: startup stream and stall ----
        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].stall, 1'b0, 32'h0);
            $display("vec %0d: stall=%0b req=%0b addr=%h valid=%0b pc_out=%h",
                     i, tbl[i].stall, imem_req, imem_addr, inst_valid, pc_out);
            chk("vec_imem_req",   32'(imem_req),   32'(tbl[i].exp_req));
            chk("vec_imem_addr",  imem_addr,       tbl[i].exp_addr);
            chk("vec_inst_valid", 32'(inst_valid), 32'(tbl[i].exp_valid));
            chk("vec_pc_out",     pc_out,          tbl[i].exp_pc);
            chk("vec_inst_out",   inst_out,        tbl[i].exp_valid ? (tbl[i].exp_pc ^ XORPAT) : 32'h0);
        end

        // ---- 3 wait states: one instruction every 4 cycles ----
        ws = 3;
        do_reset();
        nv = 0; nc = 0; prev = 32'h0;
        for (int k = 1; k <= 44; k++) begin
            cyc(1'b0, 1'b0, 32'h0);
            if (k == 4) prev = imem_addr;
            if (k >= 5) begin
                if (inst_valid) nv++;
                if (imem_addr != prev) nc++;
                prev = imem_addr;
            end
        end
        $display("ws3: valid_cycles=%0d addr_changes=%0d over 40 cycles", nv, nc);
        chk("ws3_valid_duty",   nv, 10);
        chk("ws3_addr_changes", nc, 10);

        // ---- redirect to 0x203 while busy, 2 wait states ----
        ws = 2;
        do_reset();
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            mem_drive();
            stall = 1'b1;
            if (imem_req && !imem_ack && inst_valid) found = 1;
            else tick();
        end
        chk("t4_busy_found", 32'(found), 32'h1);
        old_addr       = imem_addr;
        stall          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        tick();
        redirect_valid = 1'b0;
        chk("t4_flush_valid", 32'(inst_valid), 32'h0);
        chk("t4_drop_req",    32'(imem_req),   32'h1);
        chk("t4_addr_held",   imem_addr,       old_addr);
        got_addr = 0; new_addr = 32'h0; found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            cyc(1'b0, 1'b0, 32'h0);
            if (!got_addr && imem_addr != old_addr) begin
                got_addr = 1;
                new_addr = imem_addr;
            end
            if (inst_valid) found = 1;
        end
        $display("redirect 0x203: next addr=%h first pc_out=%h", new_addr, pc_out);
        chk("t4_valid_seen", 32'(found), 32'h1);
        chk("t4_next_addr",  new_addr,   32'h0000_0200);
        chk("t4_first_pc",   pc_out,     32'h0000_0200);
        chk("t4_first_inst", inst_out,   32'h0000_0200 ^ XORPAT);

        // ---- redirect coincident with ack, zero wait ----
        ws = 0;
        do_reset();
        repeat (4) cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 32'h0000_0300);
        chk("t5_addr_target", imem_addr,       32'h0000_0300);
        chk("t5_flush_valid", 32'(inst_valid), 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        $display("redirect+ack 0x300: valid=%0b pc_out=%h", inst_valid, pc_out);
        chk("t5_valid_2cyc", 32'(inst_valid), 32'h1);
        chk("t5_pc_2cyc",    pc_out,          32'h0000_0300);

        // ---- two redirects while dropping: last target wins ----
        ws = 3;
        do_reset();
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            mem_drive();
            stall = 1'b0;
            if (imem_req && !imem_ack && waited == 1) found = 1;
            else tick();
        end
        chk("t5b_start_found", 32'(found), 32'h1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0400;
        tick();
        redirect_valid = 1'b0;
        cyc(1'b0, 1'b1, 32'h0000_0500);
        chk("t5b_req_held", 32'(imem_req), 32'h1);
        saw400 = 0; found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            cyc(1'b0, 1'b0, 32'h0);
            if (imem_addr == 32'h0000_0400) saw400 = 1;
            if (inst_valid) found = 1;
        end
        $display("double redirect: first pc_out=%h", pc_out);
        chk("t5b_valid_seen",  32'(found),  32'h1);
        chk("t5b_no_first",    32'(saw400), 32'h0);
        chk("t5b_last_wins",   pc_out,      32'h0000_0500);

        // ---- reset mid-request with one entry buffered ----
        ws = 0;
        do_reset();
        repeat (5) cyc(1'b0, 1'b0, 32'h0);
        chk("t6_pre_valid", 32'(inst_valid), 32'h1);
        rst = 1'b1;
        mem_drive();
        tick();
        rst = 1'b0;
        chk("t6_req",    32'(imem_req),   32'h0);
        chk("t6_valid",  32'(inst_valid), 32'h0);
        chk("t6_bubble", 32'(bubble),     32'h1);
        chk("t6_addr",   imem_addr,       RESET_PC);
        cyc(1'b0, 1'b0, 32'h0);
        chk("t6_restart_req",  32'(imem_req), 32'h1);
        chk("t6_restart_addr", imem_addr,     RESET_PC);
        cyc(1'b0, 1'b0, 32'h0);
        $display("reset mid-request: restart pc_out=%h valid=%0b", pc_out, inst_valid);
        chk("t6_restart_pc", pc_out, RESET_PC);

        // ---- PC wrap ----
        cyc(1'b0, 1'b1, 32'hFFFF_FFFC);
        cyc(1'b0, 1'b0, 32'h0);
        chk("wrap_pc_top", pc_out, 32'hFFFF_FFFC);
        cyc(1'b0, 1'b0, 32'h0);
        $display("wrap: pc_out=%h after 0xfffffffc", pc_out);
        chk("wrap_pc_zero",   pc_out,          32'h0);
        chk("wrap_valid",     32'(inst_valid), 32'h1);

        // ---- randomized run against the reference model ----
        rand_data = 1;
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            if (n % 250 == 0) begin
                rand_mode = $urandom_range(0, 1);
                ws        = $urandom_range(0, 3);
                $display("random segment %0d: rand_ack=%0b ws=%0d", n / 250, rand_mode, ws);
            end
            rst = ($urandom_range(0, 299) == 0);
            mem_drive();
            stall          = ($urandom_range(0, 9) < 3);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
            tick();
            redirect_valid = 1'b0;
            rst            = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
